// File: rtl/watch_pkg.sv
// watch_pkg: shared types, segment encodings and digit constants for the display scanner
package watch_pkg;

    typedef enum logic {
        MODE_TIME = 1'b0,
        MODE_DATE = 1'b1
    } mode_e;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_CONV_A,
        SEQ_CONV_B,
        SEQ_CONV_C,
        SEQ_LOAD
    } seq_e;

    localparam int N_DIGITS = 8;
    localparam int BIN_W    = 12;

    localparam logic [3:0] BCD_BLANK = 4'hF;

    // Active-low segments, bit order g..a
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Any non-decimal code (including the blank marker) lights nothing
    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: 12-bit binary to 4-digit BCD, shift-add-3, one bit per cycle
module bin2bcd_seq
    import watch_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic [3:0][3:0]  bcd,
    output logic             done
);

    logic [BIN_W-1:0] sh;
    logic [3:0]       cnt;
    logic [3:0][3:0]  adj;

    // Add 3 to every BCD nibble that would overflow past 9 when doubled
    always_comb begin
        for (int n = 0; n < 4; n++) adj[n] = (bcd[n] >= 4'd5) ? bcd[n] + 4'd3 : bcd[n];
    end

    // Shift engine: cnt counts remaining bits, done pulses with the final shift
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh   <= '0;
            bcd  <= '0;
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                sh  <= bin;
                bcd <= '0;
                cnt <= 4'(BIN_W);
            end else if (cnt != 4'd0) begin
                {bcd, sh} <= {adj, sh} << 1;
                cnt       <= cnt - 4'd1;
                done      <= (cnt == 4'd1);
            end
        end
    end

endmodule

// File: rtl/seg_display_scan.sv
// seg_display_scan: 8-digit multiplexed 7-segment driver for time/date with tear-free frame updates
module seg_display_scan
    import watch_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int SCAN_HZ      = 8_000,
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] year,
    input  logic [3:0]  month,
    input  logic [4:0]  day,
    input  logic [5:0]  hour,
    input  logic [5:0]  minute,
    input  logic [5:0]  second,
    input  logic        mode_btn,
    output logic [7:0]  seg_an,
    output logic [7:0]  seg_cat,
    output logic        mode_led
);

    localparam int TICK_DIV = CLK_HZ / SCAN_HZ;
    localparam int TW       = $clog2(TICK_DIV);
    localparam int DW       = $clog2(DEBOUNCE_CYC);

    logic [TW-1:0]    tick_cnt;
    logic             tick;
    logic [2:0]       idx;
    logic             wrap;

    logic             btn_meta;
    logic             btn_sync;
    logic             db_level;
    logic [DW-1:0]    db_cnt;
    logic             db_rise;
    mode_e            mode;
    mode_e            mode_n;
    mode_e            snap_mode;

    seq_e             state;
    seq_e             state_n;
    logic             conv_start;
    logic             load;
    logic [BIN_W-1:0] conv_in;
    logic [3:0][3:0]  conv_bcd;
    logic             conv_done;

    logic [BIN_W-1:0] snap_b;
    logic [BIN_W-1:0] snap_c;
    logic [3:0][3:0]  res_a;
    logic [1:0][3:0]  res_b;
    logic [3:0]       digits [N_DIGITS];

    assign tick     = (tick_cnt == TW'(TICK_DIV - 1));
    assign wrap     = tick && (idx == 3'd7);
    assign db_rise  = btn_sync && !db_level && (db_cnt == DW'(DEBOUNCE_CYC - 1));
    assign mode_n   = db_rise ? ((mode == MODE_TIME) ? MODE_DATE : MODE_TIME) : mode;
    assign mode_led = (mode == MODE_DATE);

    // Scan-rate divider and digit index
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt <= '0;
            idx      <= '0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            if (tick) idx <= idx + 3'd1;
        end
    end

    // Button synchroniser and debounce: level follows input only after a full stable window
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
            db_level <= 1'b0;
            db_cnt   <= '0;
        end else begin
            btn_meta <= mode_btn;
            btn_sync <= btn_meta;
            if (btn_sync == db_level) begin
                db_cnt <= '0;
            end else if (db_cnt == DW'(DEBOUNCE_CYC - 1)) begin
                db_cnt   <= '0;
                db_level <= btn_sync;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // Display mode toggles on each debounced press
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) mode <= MODE_TIME;
        else      mode <= mode_n;
    end

    // Sequencer state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= SEQ_IDLE;
        else      state <= state_n;
    end

    // Sequencer next state: one conversion per field, then a single-cycle load
    always_comb begin
        state_n = state;
        case (state)
            SEQ_IDLE:   if (wrap)      state_n = SEQ_CONV_A;
            SEQ_CONV_A: if (conv_done) state_n = SEQ_CONV_B;
            SEQ_CONV_B: if (conv_done) state_n = SEQ_CONV_C;
            SEQ_CONV_C: if (conv_done) state_n = SEQ_LOAD;
            SEQ_LOAD:                  state_n = SEQ_IDLE;
            default:                   state_n = SEQ_IDLE;
        endcase
    end

    // Sequencer outputs: the first field goes straight from the live inputs on the wrap cycle
    always_comb begin
        conv_start = ((state == SEQ_IDLE) && wrap) ||
                     (((state == SEQ_CONV_A) || (state == SEQ_CONV_B)) && conv_done);
        load       = (state == SEQ_LOAD);
        conv_in    = (state == SEQ_IDLE)   ? ((mode_n == MODE_DATE) ? year : {6'd0, hour}) :
                     (state == SEQ_CONV_A) ? snap_b : snap_c;
    end

    bin2bcd_seq u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .bin   (conv_in),
        .bcd   (conv_bcd),
        .done  (conv_done)
    );

    // Frame snapshot of the remaining fields and per-field conversion results
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            snap_mode <= MODE_TIME;
            snap_b    <= '0;
            snap_c    <= '0;
            res_a     <= '0;
            res_b     <= '0;
        end else begin
            if ((state == SEQ_IDLE) && wrap) begin
                snap_mode <= mode_n;
                snap_b    <= (mode_n == MODE_DATE) ? {8'd0, month} : {6'd0, minute};
                snap_c    <= (mode_n == MODE_DATE) ? {7'd0, day} : {6'd0, second};
            end
            if ((state == SEQ_CONV_A) && conv_done) res_a <= conv_bcd;
            if ((state == SEQ_CONV_B) && conv_done) res_b <= conv_bcd[1:0];
        end
    end

    // Digit registers are rewritten together so a frame never shows mixed values
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int n = 0; n < N_DIGITS; n++) digits[n] <= BCD_BLANK;
        end else if (load) begin
            digits[0] <= conv_bcd[0];
            digits[1] <= conv_bcd[1];
            digits[2] <= res_b[0];
            digits[3] <= res_b[1];
            digits[4] <= res_a[0];
            digits[5] <= res_a[1];
            digits[6] <= (snap_mode == MODE_DATE) ? res_a[2] : BCD_BLANK;
            digits[7] <= (snap_mode == MODE_DATE) ? res_a[3] : BCD_BLANK;
        end
    end

    // Registered anode/cathode drive; decimal points separate the field pairs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg_an  <= 8'hFF;
            seg_cat <= 8'hFF;
        end else begin
            seg_an  <= ~(8'b1 << idx);
            seg_cat <= {!((idx == 3'd2) || (idx == 3'd4)), seg_of(digits[idx])};
        end
    end

endmodule

// File: tb/tb_seg_display_scan.sv
// tb_seg_display_scan: randomized self-checking bench with a decimal-arithmetic display model
module tb_seg_display_scan;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] year;
    logic [3:0]  month;
    logic [4:0]  day;
    logic [5:0]  hour;
    logic [5:0]  minute;
    logic [5:0]  second;
    logic        mode_btn = 1'b0;
    logic [7:0]  seg_an;
    logic [7:0]  seg_cat;
    logic        mode_led;

    int total = 0;
    int bad   = 0;
    bit exp_mode = 1'b0;

    logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    always #5 clk = ~clk;

    seg_display_scan #(
        .CLK_HZ       (6400),
        .SCAN_HZ      (100),
        .DEBOUNCE_CYC (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .year     (year),
        .month    (month),
        .day      (day),
        .hour     (hour),
        .minute   (minute),
        .second   (second),
        .mode_btn (mode_btn),
        .seg_an   (seg_an),
        .seg_cat  (seg_cat),
        .mode_led (mode_led)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected cathode byte for digit i from the current inputs and model mode
    function automatic logic [7:0] exp_cat(input int i);
        int v;
        int k;
        logic [3:0] d;
        logic [7:0] c;
        if (!exp_mode && i >= 6) begin
            d = 4'hF;
        end else begin
            if (i >= 4)      v = exp_mode ? int'(year)  : int'(hour);
            else if (i >= 2) v = exp_mode ? int'(month) : int'(minute);
            else             v = exp_mode ? int'(day)   : int'(second);
            k = (i >= 4) ? i - 4 : (i >= 2) ? i - 2 : i;
            repeat (k) v = v / 10;
            d = 4'(v % 10);
        end
        c = (d == 4'hF) ? 8'hFF : seg_tab[d];
        return (i == 2 || i == 4) ? (c & 8'h7F) : c;
    endfunction

    task automatic wait_frame_start();
        logic [7:0] prev;
        bit found;
        found = 1'b0;
        prev  = seg_an;
        for (int n = 0; n < 1200; n++) begin
            @(negedge clk);
            if (seg_an == 8'hFE && prev == 8'h7F) begin
                found = 1'b1;
                break;
            end
            prev = seg_an;
        end
        chk("frame_start", 32'(found), 32'd1);
    endtask

    task automatic check_frame(input string tag);
        logic [7:0] an_exp;
        wait_frame_start();
        repeat (50) @(negedge clk);
        chk({tag, "_led"}, 32'(mode_led), 32'(exp_mode));
        for (int i = 0; i < 8; i++) begin
            if (i != 0) repeat (64) @(negedge clk);
            an_exp = ~(8'b1 << i);
            chk($sformatf("%s_an%0d", tag, i), 32'(seg_an), 32'(an_exp));
            chk($sformatf("%s_cat%0d", tag, i), 32'(seg_cat), 32'(exp_cat(i)));
        end
    endtask

    task automatic press(input int n);
        @(negedge clk);
        mode_btn = 1'b1;
        repeat (n) @(negedge clk);
        mode_btn = 1'b0;
        repeat (30) @(negedge clk);
    endtask

    initial begin
        int n;
        year   = 12'd2021;
        month  = 4'd1;
        day    = 5'd1;
        hour   = 6'd23;
        minute = 6'd59;
        second = 6'd58;

        repeat (5) @(negedge clk);
        chk("rst_an", 32'(seg_an), 32'hFF);
        chk("rst_cat", 32'(seg_cat), 32'hFF);
        chk("rst_led", 32'(mode_led), 32'd0);
        rst = 1'b1;

        check_frame("time");

        wait_frame_start();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (seg_an == 8'hFE && n < 200);
        chk("hold_cycles", 32'(n), 32'd64);
        chk("next_an", 32'(seg_an), 32'hFD);

        press(20);
        exp_mode = 1'b1;
        chk("led_date", 32'(mode_led), 32'd1);
        check_frame("date");

        repeat (5) begin
            mode_btn = 1'b1;
            repeat (10) @(negedge clk);
            mode_btn = 1'b0;
            repeat (10) @(negedge clk);
        end
        repeat (30) @(negedge clk);
        chk("glitch_led", 32'(mode_led), 32'(exp_mode));

        wait_frame_start();
        repeat (15) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_an", 32'(seg_an), 32'hFF);
        chk("midrst_cat", 32'(seg_cat), 32'hFF);
        chk("midrst_led", 32'(mode_led), 32'd0);
        exp_mode = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        check_frame("post_rst");

        wait_frame_start();
        repeat (50) @(negedge clk);
        chk("tear_d0_before", 32'(seg_cat), 32'(exp_cat(0)));
        second = 6'd59;
        for (int i = 1; i < 8; i++) begin
            repeat (64) @(negedge clk);
            chk($sformatf("tear_mid_cat%0d", i), 32'(seg_cat), 32'(exp_cat(i)));
        end
        wait_frame_start();
        repeat (5) @(negedge clk);
        chk("tear_d0_old", 32'(seg_cat), 32'h80);
        repeat (45) @(negedge clk);
        chk("tear_d0_new", 32'(seg_cat), 32'(exp_cat(0)));

        for (int r = 0; r < 6; r++) begin
            year   = 12'($urandom_range(0, 4095));
            month  = 4'($urandom_range(0, 15));
            day    = 5'($urandom_range(0, 31));
            hour   = 6'($urandom_range(0, 63));
            minute = 6'($urandom_range(0, 63));
            second = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 1) begin
                press(20);
                exp_mode = !exp_mode;
            end
            check_frame($sformatf("rnd%0d", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
